// File: rtl/mdu.sv
// mdu -- multiply/divide unit for the E stage, owning the HI/LO register pair.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset
//   MD_A_E    : operand A (forwarded rs)
//   MD_B_E    : operand B (forwarded rt)
//   MDOp_E    : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu
//   start_E   : qualifies MDOp_E for one cycle
//   MDRd_E    : read select, 0 = HI, 1 = LO
//   busy_E    : high while a multi-cycle operation is in flight
//   MD_out_E  : combinational mfhi/mflo result from the committed registers
//
// Configuration:
//   MDU_MADD_EN : when defined, madd/maddu accumulate the product into {HI,LO};
//                 otherwise opcodes 7 and 8 behave as none.
//
// Operands are latched at accept and the result is computed from the latched copies, so
// HI/LO only change on the edge that drops busy_E.

module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MD_A_E,
    input  logic [31:0] MD_B_E,
    input  logic [3:0]  MDOp_E,
    input  logic        start_E,
    input  logic        MDRd_E,
    output logic        busy_E,
    output logic [31:0] MD_out_E
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
`endif

    // Counter load values are latency-1; the commit happens on the edge that sees zero.
    localparam logic [3:0] MulLastCnt = 4'd4;
    localparam logic [3:0] DivLastCnt = 4'd9;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mul;
    logic        is_div;

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        b_zero;
    logic [31:0] b_safe;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;

`ifdef MDU_MADD_EN
    assign is_mul = (MDOp_E == OpMult) || (MDOp_E == OpMultu) ||
                    (MDOp_E == OpMadd) || (MDOp_E == OpMaddu);
`else
    assign is_mul = (MDOp_E == OpMult) || (MDOp_E == OpMultu);
`endif
    assign is_div = (MDOp_E == OpDiv) || (MDOp_E == OpDivu);

    // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    // Divide on magnitudes and fix signs afterwards; this makes 0x80000000 / -1 wrap to
    // 0x80000000 without relying on signed-overflow behaviour of the operator.
    assign b_zero = (b_q == 32'd0);
    assign abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b  = b_zero ? 32'd1 : (b_q[31] ? (~b_q + 32'd1) : b_q);
    assign b_safe = b_zero ? 32'd1 : b_q;
    assign sq_mag = abs_a / abs_b;
    assign sr_mag = abs_a % abs_b;
    assign sq     = (a_q[31] ^ b_q[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign sr     = a_q[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign uq     = a_q / b_safe;
    assign ur     = a_q % b_safe;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start_E) begin
                    if (is_mul || is_div) begin
                        state_d = StBusy;
                        cnt_d   = is_div ? DivLastCnt : MulLastCnt;
                        op_d    = MDOp_E;
                        a_d     = MD_A_E;
                        b_d     = MD_B_E;
                    end else if (MDOp_E == OpMthi) begin
                        hi_d = MD_A_E;
                    end else if (MDOp_E == OpMtlo) begin
                        lo_d = MD_A_E;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    case (op_q)
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        OpDiv: begin
                            if (!b_zero) begin
                                lo_d = sq;
                                hi_d = sr;
                            end
                        end
                        OpDivu: begin
                            if (!b_zero) begin
                                lo_d = uq;
                                hi_d = ur;
                            end
                        end
`ifdef MDU_MADD_EN
                        OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_E   = (state_q == StBusy);
    // HI/LO are cleared asynchronously, so this reads 0 throughout reset.
    assign MD_out_E = MDRd_E ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed self-checking bench for mdu with hand-computed expected values.

module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] MD_A_E;
    logic [31:0] MD_B_E;
    logic [3:0]  MDOp_E;
    logic        start_E;
    logic        MDRd_E;
    logic        busy_E;
    logic [31:0] MD_out_E;

    int vectors;
    int miscompares;

    mdu dut (
        .clk      (clk),
        .reset    (reset),
        .MD_A_E   (MD_A_E),
        .MD_B_E   (MD_B_E),
        .MDOp_E   (MDOp_E),
        .start_E  (start_E),
        .MDRd_E   (MDRd_E),
        .busy_E   (busy_E),
        .MD_out_E (MD_out_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reads HI then LO through the output mux.
    task automatic check_hl(input string tag, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        MDRd_E = 1'b0;
        #1;
        check_eq({tag, "_hi"}, MD_out_E, exp_hi);
        MDRd_E = 1'b1;
        #1;
        check_eq({tag, "_lo"}, MD_out_E, exp_lo);
    endtask

    // Issues one start, then counts negedge samples with busy_E high (bounded).
    // When inject is set, a second start is driven during the first busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int cyc);
        @(negedge clk);
        MDOp_E  = op;
        MD_A_E  = a;
        MD_B_E  = b;
        start_E = 1'b1;
        @(negedge clk);
        start_E = 1'b0;
        cyc = 0;
        while (busy_E && cyc < 20) begin
            cyc++;
            if (inject && cyc == 1) begin
                MDOp_E  = 4'd1;
                MD_A_E  = 32'd5;
                MD_B_E  = 32'd5;
                start_E = 1'b1;
            end
            @(negedge clk);
            start_E = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        MD_A_E  = 32'd0;
        MD_B_E  = 32'd0;
        MDOp_E  = 4'd0;
        start_E = 1'b0;
        MDRd_E  = 1'b0;

        #1;
        check_eq("rst_busy", 32'(busy_E), 32'd0);
        check_hl("rst", 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, cyc);
        check_eq("mult_cyc", 32'(cyc), 32'd5);
        check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, cyc);
        check_eq("multu_cyc", 32'(cyc), 32'd5);
        check_hl("multu", 32'd1, 32'hFFFF_FFFE);
        @(negedge clk);
        check_eq("ignored_start_busy", 32'(busy_E), 32'd0);
        check_hl("ignored_start", 32'd1, 32'hFFFF_FFFE);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        check_eq("div_cyc", 32'(cyc), 32'd10);
        check_hl("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(4'd4, 32'd5, 32'd0, 1'b0, cyc);
        check_eq("divu0_cyc", 32'(cyc), 32'd10);
        check_hl("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        check_hl("div_ovf", 32'd0, 32'h8000_0000);

        run_op(4'd4, 32'd100, 32'd7, 1'b0, cyc);
        check_hl("divu_100_7", 32'd2, 32'd14);

        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, cyc);
        check_hl("div_7_m2", 32'd1, 32'hFFFF_FFFD);

        run_op(4'd5, 32'h1234, 32'd0, 1'b0, cyc);
        check_eq("mthi_cyc", 32'(cyc), 32'd0);
        check_hl("mthi", 32'h1234, 32'hFFFF_FFFD);

        run_op(4'd6, 32'hABCD, 32'd0, 1'b0, cyc);
        check_eq("mtlo_cyc", 32'(cyc), 32'd0);
        check_hl("mtlo", 32'h1234, 32'hABCD);

        // mfhi/mflo during busy must show the pre-operation values.
        @(negedge clk);
        MDOp_E  = 4'd1;
        MD_A_E  = 32'd3;
        MD_B_E  = 32'd4;
        start_E = 1'b1;
        @(negedge clk);
        start_E = 1'b0;
        check_eq("mul34_busy", 32'(busy_E), 32'd1);
        check_hl("read_during_busy", 32'h1234, 32'hABCD);
        cyc = 0;
        while (busy_E && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("mul34_cyc", 32'(cyc), 32'd5);
        check_hl("mul34", 32'd0, 32'd12);

        run_op(4'd0, 32'd99, 32'd1, 1'b0, cyc);
        check_eq("none_cyc", 32'(cyc), 32'd0);
        check_hl("none", 32'd0, 32'd12);
        run_op(4'd15, 32'd99, 32'd1, 1'b0, cyc);
        check_eq("op15_cyc", 32'(cyc), 32'd0);
        check_hl("op15", 32'd0, 32'd12);

        run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, cyc);
        run_op(4'd8, 32'd1, 32'd1, 1'b0, cyc);
`ifdef MDU_MADD_EN
        check_eq("maddu_cyc", 32'(cyc), 32'd5);
        check_hl("maddu", 32'd1, 32'd0);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, cyc);
        check_eq("madd_cyc", 32'(cyc), 32'd5);
        check_hl("madd", 32'd0, 32'hFFFF_FFFF);
`else
        check_eq("maddu_off_cyc", 32'(cyc), 32'd0);
        check_hl("maddu_off", 32'd0, 32'hFFFF_FFFF);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, cyc);
        check_eq("madd_off_cyc", 32'(cyc), 32'd0);
        check_hl("madd_off", 32'd0, 32'hFFFF_FFFF);
`endif

        // Reset in the fourth busy cycle of a divide aborts it with no commit.
        @(negedge clk);
        MDOp_E  = 4'd4;
        MD_A_E  = 32'd100;
        MD_B_E  = 32'd7;
        start_E = 1'b1;
        @(negedge clk);
        start_E = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_busy_before", 32'(busy_E), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy_E), 32'd0);
        check_hl("abort", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("abort_later_busy", 32'(busy_E), 32'd0);
        check_hl("abort_later", 32'd0, 32'd0);

        // Start driven together with reset release is taken on the very next edge.
        #2;
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        MDOp_E  = 4'd1;
        MD_A_E  = 32'd2;
        MD_B_E  = 32'd3;
        start_E = 1'b1;
        @(negedge clk);
        start_E = 1'b0;
        check_eq("first_start_busy", 32'(busy_E), 32'd1);
        cyc = 0;
        while (busy_E && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("first_start_cyc", 32'(cyc), 32'd5);
        check_hl("first_start", 32'd0, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
